ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the decoded operation from the decode stage: aluop, alusel, operand 1, operand 2, destination register and write-enable.
- Produces the writeback data for the EX/MEM register and a HI/LO write.
- Contains a multi-cycle radix-2 restoring divider for DIV/DIVU. It holds the pipeline through a stall request until the quotient and remainder are ready.

Parameters:
DIV_CYCLES, 32, number of iteration cycles in the BUSY state (equals the data width)

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-low; sampled on rising clk; 0 = reset asserted
aluop_i  input  8  operation code from decode
alusel_i  input  3  result class from decode: 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH
reg1_i  input  32  operand 1 (register value or zero-extended immediate)
reg2_i  input  32  operand 2 (register value or zero-extended immediate)
wd_i  input  5  destination register address
wreg_i  input  1  destination write enable
flush_i  input  1  pipeline flush; aborts any in-flight division
wd_o  output  5  destination address to EX/MEM
wreg_o  output  1  write enable to EX/MEM
wdata_o  output  32  result to EX/MEM
whilo_o  output  1  HI/LO write strobe
hi_o  output  32  remainder
lo_o  output  32  quotient
stallreq_o  output  1  stall request to pipeline control

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE; iteration counter and datapath registers clear.
  - While rst=0, every output is forced to 0 combinationally.
- aluop encodings:
  - AND 00100100, OR 00100101, XOR 00100110, NOR 00100111
  - SLL 01111100, SRL 00000010, SRA 00000011
  - ADDU 00100001, SUBU 00100011, SLT 00101010
  - DIV 00011010, DIVU 00011011, NOP 00000000
- Non-divide ops are combinational, with zero latency.
  - wd_o = wd_i and wreg_o = wreg_i.
  - wdata_o is selected by alusel_i.
  - Shifts use reg1_i[4:0] as the shift amount and reg2_i as the value.
  - SLT is a signed compare yielding 0 or 1.
  - ADDU/SUBU wrap modulo 2^32 with no overflow trap.
  - An unknown alusel or aluop gives wdata_o = 0.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If aluop_i is DIV/DIVU, flush_i=0 and reg2_i≠0:
    - Latch the operand magnitudes (absolute values for DIV), the sign flags, and the op.
    - Counter = 0; go to BUSY; stallreq_o=1 in this cycle.
  - If reg2_i=0: go directly to DONE with the result forced to hi=0, lo=0; stallreq_o=1 in this cycle.
- BUSY:
  - stallreq_o=1.
  - Each cycle performs one shift-subtract step on a 65-bit partial remainder and increments the counter.
  - After DIV_CYCLES steps, go to DONE.
- DONE:
  - stallreq_o=0, whilo_o=1.
  - For DIV: lo_o = quotient, negated if the operand signs differ; hi_o = remainder, carrying the sign of the dividend.
  - For DIVU: unsigned results.
  - Return to IDLE next cycle.
  - whilo_o is 0 in every other state.
- Divide latency:
  - The issue cycle plus 32 BUSY cycles give 33 cycles with stallreq_o=1; the result is valid in cycle 34.
  - Divide-by-zero: 1 stall cycle; the result is valid in the 2nd cycle.
- Pipeline control holds the ex inputs stable while stallreq_o=1.
  - In DONE the divider ignores the inputs, so a DIV held at the inputs does not relaunch.
- For DIV/DIVU: wreg_o = 0 and wdata_o = 0 (they write HI/LO only).
- flush_i=1 in any state: FSM goes to IDLE next edge, whilo_o=0, stallreq_o=0 in that cycle, and the result is discarded.
- Reset has priority over flush. Reset mid-division aborts with no whilo_o pulse.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).

Test Plan:
- Logic and shift: OR 0x0000F0F0 | 0x00000F0F → wdata_o=0x0000FFFF, wreg_o=wreg_i, zero latency. SRA with reg1=4, reg2=0x80000000 → 0xF8000000.
- DIVU 100/7 → stallreq_o high exactly 33 cycles; next cycle whilo_o=1, lo_o=14, hi_o=2; whilo_o pulses for one cycle only.
- DIV −7/2 (0xFFFFFFF9 / 2) → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIVU 5/0 → stallreq_o high 1 cycle, then whilo_o=1 with hi_o=0, lo_o=0.
- Flush at BUSY cycle 10 → stallreq_o=0 that cycle, FSM in IDLE, no whilo_o pulse; a following DIVU 9/3 completes normally with lo=3, hi=0.
- rst=0 asserted at BUSY cycle 5 → all outputs 0 while low; after release, FSM is IDLE and no stale whilo_o appears.

Source files
------------

// File: rtl/ex_div.sv
// ex_div: MIPS execute stage with a multi-cycle radix-2 restoring divider.
// ALU ops (logic/shift/arith) are combinational; DIV/DIVU stall the pipe.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset (0 = in reset)
//   aluop_i     operation code from decode
//   alusel_i    result class (000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH)
//   reg1_i      operand 1 (shift amount in [4:0] for shifts)
//   reg2_i      operand 2 (value to shift for shifts)
//   wd_i        destination register address
//   wreg_i      destination write enable
//   flush_i     pipeline flush, aborts an in-flight division
//   wd_o        destination address to EX/MEM
//   wreg_o      write enable to EX/MEM (0 for DIV/DIVU)
//   wdata_o     result to EX/MEM (0 for DIV/DIVU)
//   whilo_o     HI/LO write strobe, one cycle in DONE
//   hi_o        remainder
//   lo_o        quotient
//   stallreq_o  stall request to pipeline control
module ex_div #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_SLT  = 8'b00101010;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_rem;
    logic [31:0] r_dvsr;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_div;
    logic        w_signed;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [64:0] w_shift;
    logic [33:0] w_sub;
    logic [64:0] w_step;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_alu;
    logic        w_slt;

    assign w_is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign w_signed = (aluop_i == OP_DIV);

    assign w_abs1 = (w_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
    assign w_abs2 = (w_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

    // Partial remainder lives in [64:32], quotient bits shift in at [0].
    // A borrow out of the 34-bit subtract means the trial subtract fails.
    assign w_shift = r_rem << 1;
    assign w_sub   = {1'b0, w_shift[64:32]} - {2'b00, r_dvsr};
    assign w_step  = w_sub[33] ? w_shift
                               : {w_sub[32:0], w_shift[31:1], 1'b1};
    assign w_q     = w_step[31:0];
    assign w_r     = 32'(w_step >> 32);

    assign w_slt = $signed(reg1_i) < $signed(reg2_i);

    always_comb begin
        w_alu = 32'd0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  w_alu = reg1_i & reg2_i;
                    OP_OR:   w_alu = reg1_i | reg2_i;
                    OP_XOR:  w_alu = reg1_i ^ reg2_i;
                    OP_NOR:  w_alu = ~(reg1_i | reg2_i);
                    default: w_alu = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  w_alu = reg2_i << reg1_i[4:0];
                    OP_SRL:  w_alu = reg2_i >> reg1_i[4:0];
                    OP_SRA:  w_alu = 32'($signed(reg2_i) >>> reg1_i[4:0]);
                    default: w_alu = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADDU: w_alu = reg1_i + reg2_i;
                    OP_SUBU: w_alu = reg1_i - reg2_i;
                    OP_SLT:  w_alu = {31'd0, w_slt};
                    default: w_alu = 32'd0;
                endcase
            end
            default: w_alu = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_rem   <= 65'd0;
            r_dvsr  <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_div) begin
                        if (reg2_i == 32'd0) begin
                            r_hi    <= 32'd0;
                            r_lo    <= 32'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_rem   <= {33'd0, w_abs1};
                            r_dvsr  <= w_abs2;
                            r_neg_q <= w_signed & (reg1_i[31] ^ reg2_i[31]);
                            r_neg_r <= w_signed & reg1_i[31];
                            r_cnt   <= 6'd0;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_step;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST_CNT) begin
                        // Sign fix-up folded into the final step.
                        r_lo    <= r_neg_q ? (32'd0 - w_q) : w_q;
                        r_hi    <= r_neg_r ? (32'd0 - w_r) : w_r;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    logic w_done;
    logic w_stall;

    assign w_done  = rst && !flush_i && (r_state == S_DONE);
    assign w_stall = rst && !flush_i &&
                     (((r_state == S_IDLE) && w_is_div) ||
                      (r_state == S_BUSY));

    assign wd_o       = rst ? wd_i : 5'd0;
    assign wreg_o     = rst && wreg_i && !w_is_div;
    assign wdata_o    = (rst && !w_is_div) ? w_alu : 32'd0;
    assign whilo_o    = w_done;
    assign hi_o       = w_done ? r_hi : 32'd0;
    assign lo_o       = w_done ? r_lo : 32'd0;
    assign stallreq_o = w_stall;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed plus random checks of ex_div against an
// arithmetic reference model.
module tb_ex_div;

    localparam logic [7:0] AND_ = 8'b00100100;
    localparam logic [7:0] OR_  = 8'b00100101;
    localparam logic [7:0] XOR_ = 8'b00100110;
    localparam logic [7:0] NOR_ = 8'b00100111;
    localparam logic [7:0] SLL_ = 8'b01111100;
    localparam logic [7:0] SRL_ = 8'b00000010;
    localparam logic [7:0] SRA_ = 8'b00000011;
    localparam logic [7:0] ADDU = 8'b00100001;
    localparam logic [7:0] SUBU = 8'b00100011;
    localparam logic [7:0] SLT_ = 8'b00101010;
    localparam logic [7:0] DIV_ = 8'b00011010;
    localparam logic [7:0] DIVU = 8'b00011011;
    localparam logic [7:0] NOP_ = 8'b00000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_div dut (
        .clk(clk), .rst(rst),
        .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq_o(stallreq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic we);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
        wd_i = wd; wreg_i = we;
    endtask

    // Reference ALU: result class selects the op family, anything else is 0.
    function automatic logic [31:0] m_alu(input logic [7:0] op,
                                          input logic [2:0] sel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        if (sel == 3'b001 && op == AND_) return a & b;
        if (sel == 3'b001 && op == OR_)  return a | b;
        if (sel == 3'b001 && op == XOR_) return a ^ b;
        if (sel == 3'b001 && op == NOR_) return ~(a | b);
        if (sel == 3'b010 && op == SLL_) return b << sh;
        if (sel == 3'b010 && op == SRL_) return b >> sh;
        if (sel == 3'b010 && op == SRA_) return 32'($signed(b) >>> sh);
        if (sel == 3'b100 && op == ADDU) return a + b;
        if (sel == 3'b100 && op == SUBU) return a - b;
        if (sel == 3'b100 && op == SLT_)
            return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    // Reference divide in 64-bit arithmetic; truncating division with
    // remainder taking the dividend's sign, divide-by-zero gives 0/0.
    task automatic m_div(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] lo,
                         output logic [31:0] hi);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo = 32'd0; hi = 32'd0;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            q = sa / sb;
            r = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int n;
        int pulses;
        drive(op, 3'b100, a, b, 5'd9, 1'b1);
        #1;
        chk({tag, "_wreg"}, 32'(wreg_o), 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        n = 0;
        pulses = 0;
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            if (whilo_o !== 1'b0) pulses++;
            tick();
            #1;
        end
        chk({tag, "_stalls"}, 32'(n), (b == 32'd0) ? 32'd1 : 32'd33);
        chk({tag, "_early_whilo"}, 32'(pulses), 32'd0);
        chk({tag, "_whilo"}, 32'(whilo_o), 32'd1);
        chk({tag, "_lo"}, lo_o, exp_lo);
        chk({tag, "_hi"}, hi_o, exp_hi);
        tick();
        drive(NOP_, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk({tag, "_whilo_once"}, 32'(whilo_o), 32'd0);
        chk({tag, "_stall_after"}, 32'(stallreq_o), 32'd0);
    endtask

    initial begin
        logic [7:0]  ops  [10];
        logic [2:0]  sels [10];
        logic [31:0] a, b, elo, ehi;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic        sgn;
        int          k, pulses, stalls;

        ops  = '{AND_, OR_, XOR_, NOR_, SLL_, SRL_, SRA_, ADDU, SUBU, SLT_};
        sels = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                 3'b100, 3'b100, 3'b100};

        rst = 1'b0;
        flush_i = 1'b0;
        drive(DIV_, 3'b100, 32'd100, 32'd7, 5'd17, 1'b1);
        tick();
        tick();
        chk("rst_ctl", {24'd0, wd_o, wreg_o, whilo_o, stallreq_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_hilo", hi_o | lo_o, 32'd0);
        drive(NOP_, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b1;
        tick();

        drive(OR_, 3'b001, 32'h0000F0F0, 32'h00000F0F, 5'd5, 1'b1);
        #1;
        chk("or_data", wdata_o, 32'h0000FFFF);
        chk("or_wreg", 32'(wreg_o), 32'd1);
        chk("or_wd", 32'(wd_o), 32'd5);
        chk("or_stall", 32'(stallreq_o), 32'd0);

        drive(SRA_, 3'b010, 32'd4, 32'h80000000, 5'd6, 1'b0);
        #1;
        chk("sra_data", wdata_o, 32'hF8000000);
        chk("sra_wreg", 32'(wreg_o), 32'd0);

        drive(SLT_, 3'b100, 32'hFFFFFFFF, 32'd1, 5'd7, 1'b1);
        #1;
        chk("slt_neg", wdata_o, 32'd1);
        drive(ADDU, 3'b011, 32'd3, 32'd4, 5'd7, 1'b1);
        #1;
        chk("bad_sel", wdata_o, 32'd0);
        tick();

        run_div("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("div_m7_2", DIV_, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("div_min_m1", DIV_, 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, 32'd0);
        run_div("divu_5_0", DIVU, 32'd5, 32'd0, 32'd0, 32'd0);

        // Flush in the 10th BUSY cycle.
        drive(DIVU, 3'b100, 32'hFFFFFFFF, 32'd3, 5'd1, 1'b0);
        #1;
        repeat (10) tick();
        flush_i = 1'b1;
        #1;
        chk("flush_stall", 32'(stallreq_o), 32'd0);
        chk("flush_whilo", 32'(whilo_o), 32'd0);
        tick();
        flush_i = 1'b0;
        run_div("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 32'd0);

        // Reset in the 5th BUSY cycle.
        drive(DIV_, 3'b100, 32'd1000, 32'hFFFFFFFD, 5'd12, 1'b1);
        #1;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("mrst_ctl", {24'd0, wd_o, wreg_o, whilo_o, stallreq_o}, 32'd0);
        chk("mrst_data", wdata_o | hi_o | lo_o, 32'd0);
        tick();
        chk("mrst_ctl2", {24'd0, wd_o, wreg_o, whilo_o, stallreq_o}, 32'd0);
        drive(NOP_, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b1;
        pulses = 0;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            #1;
            if (whilo_o !== 1'b0) pulses++;
            if (stallreq_o !== 1'b0) stalls++;
        end
        chk("mrst_no_whilo", 32'(pulses), 32'd0);
        chk("mrst_no_stall", 32'(stalls), 32'd0);
        run_div("divu_50_5", DIVU, 32'd50, 32'd5, 32'd10, 32'd0);

        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 9));
            op = ops[k];
            sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                              : sels[k];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = a % 40;
            drive(op, sel, a, b, 5'($urandom), 1'b1);
            #1;
            chk("rnd_alu", wdata_o, m_alu(op, sel, a, b));
        end
        tick();

        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            m_div(sgn, a, b, elo, ehi);
            run_div(sgn ? "rnd_div" : "rnd_divu", sgn ? DIV_ : DIVU,
                    a, b, elo, ehi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
